// File: rtl/noc_xy_route_buffer.sv
// Router input stage: buffers the merged packet stream in a small FIFO and
// steers the head packet to one of five output ports using XY routing.
// Output port order in out_valid/out_ready: bit0 E, bit1 W, bit2 N, bit3 S, bit4 L.
module noc_xy_route_buffer #(
  parameter int WIDTH   = 39,
  parameter int DEPTH   = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic [4:0]               out_valid,
  input  logic [4:0]               out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0]  LX       = 2'(LOCAL_X);
  localparam logic [1:0]  LY       = 2'(LOCAL_Y);

  // Control state mirrors the fill level so ready/valid come straight from flops.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [AW:0]       count, count_next;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              push, pop;
  logic [WIDTH-1:0]  head;
  logic [1:0]        dst_x, dst_y;
  logic [4:0]        route;

  assign head      = mem[rd_ptr];
  assign dst_x     = head[WIDTH-1 -: 2];
  assign dst_y     = head[WIDTH-3 -: 2];

  assign in_ready  = (state != FULL);
  assign push      = in_valid && in_ready;
  assign out_data  = head;
  assign occupancy = count;
  assign out_valid = (state != EMPTY) ? route : 5'b00000;
  // Only the selected port's ready matters, since out_valid is one-hot.
  assign pop       = |(out_valid & out_ready);

  // XY dimension-order decode of the head packet: resolve X before Y.
  always_comb begin
    route = 5'b10000;
    if (dst_x > LX)      route = 5'b00001;
    else if (dst_x < LX) route = 5'b00010;
    else if (dst_y > LY) route = 5'b00100;
    else if (dst_y < LY) route = 5'b01000;
  end

  // Next fill level and FSM transition from the push/pop handshakes.
  always_comb begin
    count_next = count;
    state_next = state;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
    case (state)
      EMPTY: begin
        if (push) state_next = PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop && count == FULL_CNT - (AW+1)'(1))
          state_next = FULL;
        else if (pop && !push && count == (AW+1)'(1))
          state_next = EMPTY;
      end
      FULL: begin
        if (pop) state_next = PARTIAL;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Control registers: pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Packet storage carries no reset; contents are only observed while valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_noc_xy_route_buffer.sv
// Randomized and directed bench for noc_xy_route_buffer with LOCAL=(1,1).
// A queue-based model tracks accepted packets; outputs are compared every cycle.
module tb_noc_xy_route_buffer;

  localparam int WIDTH = 39;
  localparam int DEPTH = 4;
  localparam int LX    = 1;
  localparam int LY    = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic [4:0]        out_valid;
  logic [4:0]        out_ready = '0;
  logic [WIDTH-1:0]  out_data;
  logic [2:0]        occupancy;

  int vectors = 0;
  int miscompares = 0;
  int seq = 0;
  logic [WIDTH-1:0] q[$];

  noc_xy_route_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LOCAL_X(LX), .LOCAL_Y(LY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] mk(input int dx, input int dy);
    logic [WIDTH-1:0] p;
    p = {2'(dx), 2'(dy), 4'hA, 31'(seq)};
    seq++;
    return p;
  endfunction

  // Routing rule: X dimension first, then Y, else local.
  function automatic logic [4:0] exp_port(input logic [WIDTH-1:0] p);
    int dx;
    int dy;
    dx = int'(p[38:37]);
    dy = int'(p[36:35]);
    if (dx > LX) return 5'b00001;
    if (dx < LX) return 5'b00010;
    if (dy > LY) return 5'b00100;
    if (dy < LY) return 5'b01000;
    return 5'b10000;
  endfunction

  task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [4:0] ev;
    ev = (q.size() != 0) ? exp_port(q[0]) : 5'b00000;
    check_lit("out_valid", 64'(out_valid), 64'(ev));
    check_lit("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    check_lit("occupancy", 64'(occupancy), 64'(q.size()));
    if (q.size() != 0) check_lit("out_data", 64'(out_data), 64'(q[0]));
  endtask

  // One clock cycle: apply inputs, compare, then advance the model at the edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic [4:0] r);
    logic psh;
    logic pp;
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
    check_model();
    psh = v && (q.size() < DEPTH);
    pp = (q.size() != 0) && ((r & exp_port(q[0])) != 5'b00000);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (psh) q.push_back(d);
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] r);
    cycle(1'b0, '0, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) idle(5'b11111);
  endtask

  initial begin
    logic [WIDTH-1:0] p;
    // Reset values
    #2;
    check_lit("rst_out_valid", 64'(out_valid), 64'd0);
    check_lit("rst_in_ready", 64'(in_ready), 64'd1);
    check_lit("rst_occupancy", 64'(occupancy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Local destination: one cycle latency, then pop empties the buffer
    p = mk(1, 1);
    cycle(1'b1, p, 5'b00000);
    in_valid = 1'b0;
    #1;
    check_lit("local_valid", 64'(out_valid), 64'h10);
    check_lit("local_data", 64'(out_data), 64'(p));
    idle(5'b10000);
    check_lit("local_popped", 64'(occupancy), 64'd0);

    // E, W, N, S in order; X beats Y for (3,0)
    cycle(1'b1, mk(3, 0), 5'b00000);
    cycle(1'b1, mk(0, 2), 5'b00000);
    cycle(1'b1, mk(1, 3), 5'b00000);
    cycle(1'b1, mk(1, 0), 5'b00000);
    #1;
    check_lit("dir_E", 64'(out_valid), 64'h01);
    idle(5'b00001);
    #1;
    check_lit("dir_W", 64'(out_valid), 64'h02);
    idle(5'b00010);
    #1;
    check_lit("dir_N", 64'(out_valid), 64'h04);
    idle(5'b00100);
    #1;
    check_lit("dir_S", 64'(out_valid), 64'h08);
    idle(5'b01000);
    check_lit("dir_empty", 64'(occupancy), 64'd0);

    // Fill to full; fifth packet refused; drain in order
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(i % 4, (i + 1) % 4), 5'b00000);
    check_lit("full_in_ready", 64'(in_ready), 64'd0);
    check_lit("full_occupancy", 64'(occupancy), 64'd4);
    idle(5'b11111);
    check_lit("after_pop_ready", 64'(in_ready), 64'd1);
    drain();

    // Steady push+pop at count 2 for 10 cycles
    cycle(1'b1, mk(3, 3), 5'b00000);
    cycle(1'b1, mk(2, 0), 5'b00000);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, mk(2 + (i % 2), i % 4), 5'b11111);
      check_lit("steady_occ", 64'(occupancy), 64'd2);
    end
    drain();

    // Head-of-line blocking: head N stalled, E ready but must wait
    cycle(1'b1, mk(1, 3), 5'b00000);
    cycle(1'b1, mk(3, 1), 5'b00001);
    for (int i = 0; i < 3; i++) idle(5'b00001);
    #1;
    check_lit("hol_blocked", 64'(out_valid), 64'h04);
    idle(5'b00100);
    #1;
    check_lit("hol_released", 64'(out_valid), 64'h01);
    drain();

    // Async reset with 3 buffered packets
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(0, i), 5'b00000);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("arst_valid", 64'(out_valid), 64'd0);
    check_lit("arst_occupancy", 64'(occupancy), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    p = mk(2, 2);
    cycle(1'b1, p, 5'b00000);
    in_valid = 1'b0;
    #1;
    check_lit("post_rst_valid", 64'(out_valid), 64'h01);
    check_lit("post_rst_data", 64'(out_data), 64'(p));
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r;
      r = 5'($urandom);
      if ($urandom_range(0, 3) == 0) r = 5'b00000;
      cycle(1'($urandom_range(0, 99) < 60), mk($urandom_range(0, 3), $urandom_range(0, 3)), r);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
